// File: rtl/gf2_poly_mulmod_ds.sv
// Digit-serial GF(2)[x] multiply/square/multiply-accumulate modulo a programmable degree-W modulus.
// Each RUN cycle consumes D bits of B, MSB first, through a chained shift-reduce-add network.
module gf2_poly_mulmod_ds #(
  parameter int W = 144,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mod_sel,
  input  logic [0:W]   mod_dat,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [0:W-1] op_a_dat,
  input  logic [0:W-1] op_b_dat,
  output logic         busy,
  output logic         done,
  output logic [0:W-1] res_dat,
  output logic         mod_err
);

  localparam int NB = (W + D - 1) / D;
  localparam int BW = NB * D;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  // state   | meaning
  // ST_IDLE | waiting for an accepted start
  // ST_RUN  | consuming one digit of breg per cycle, NB cycles
  // ST_DONE | result just written, done pulse; may accept a new start
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t          state, state_nxt;
  logic [W:0]      modreg;
  logic [W-1:0]    areg, acc, acc_nxt;
  logic [BW-1:0]   breg;
  logic [1:0]      mreg;
  logic [CW-1:0]   cnt;
  logic            accept, last;

  assign mod_err = ~modreg[W];
  assign busy    = (state == ST_RUN);
  assign done    = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !mod_err) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == '0) begin
          last      = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start && !mod_err) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Horner step per bit: shift, fold the x^W term back via the modulus, add A if the B bit is set.
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < D; i++) begin
      acc_nxt = (acc_nxt << 1)
              ^ (acc_nxt[W-1] ? modreg[W-1:0] : '0)
              ^ (breg[BW-1-i] ? areg : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      modreg  <= '0;
      areg    <= '0;
      breg    <= '0;
      acc     <= '0;
      mreg    <= '0;
      cnt     <= '0;
      res_dat <= '0;
    end else begin
      state <= state_nxt;
      if (mod_sel && !busy)
        modreg <= mod_dat;
      if (accept) begin
        areg <= op_a_dat;
        breg <= (mode == 2'b10) ? BW'(op_a_dat) : BW'(op_b_dat);
        acc  <= '0;
        mreg <= mode;
        cnt  <= CW'(NB - 1);
      end else if (busy) begin
        acc  <= acc_nxt;
        breg <= breg << D;
        if (!last)
          cnt <= cnt - 1'b1;
        else
          res_dat <= (mreg == 2'b01) ? (acc_nxt ^ res_dat) : acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gf2_poly_mulmod_ds.sv
// Scoreboard bench: directed vectors push expected results, a negedge monitor checks on done.
// Two instances cover the W=8/D=3 and W=144/D=1 configurations.
module tb_gf2_poly_mulmod_ds;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         ms8, st8, bz8, dn8, me8;
  logic [8:0]   md8;
  logic [1:0]   mo8;
  logic [7:0]   a8, b8, r8;

  logic         ms1, st1, bz1, dn1, me1;
  logic [144:0] md1;
  logic [1:0]   mo1;
  logic [143:0] a1, b1, r1;

  gf2_poly_mulmod_ds #(.W(8), .D(3)) dut8 (
    .clk(clk), .rst(rst), .mod_sel(ms8), .mod_dat(md8), .start(st8), .mode(mo8),
    .op_a_dat(a8), .op_b_dat(b8), .busy(bz8), .done(dn8), .res_dat(r8), .mod_err(me8)
  );

  gf2_poly_mulmod_ds #(.W(144), .D(1)) dut144 (
    .clk(clk), .rst(rst), .mod_sel(ms1), .mod_dat(md1), .start(st1), .mode(mo1),
    .op_a_dat(a1), .op_b_dat(b1), .busy(bz1), .done(dn1), .res_dat(r1), .mod_err(me1)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0]   q8[$];
  logic [143:0] q1[$];
  logic [7:0]   e8;
  logic [143:0] e1;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dn8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done8_unexpected: got done=1 expected no done, res=%h", r8);
      end else begin
        e8 = q8.pop_front();
        chk("res8", r8, e8);
      end
    end
    if (dn1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done144_unexpected: got done=1 expected no done, res=%h", r1);
      end else begin
        e1 = q1.pop_front();
        chk("res144", r1, e1);
      end
    end
  end

  task automatic launch8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] e, input logic sel, input logic [8:0] md);
    mo8 = m; a8 = a; b8 = b; st8 = 1'b1; ms8 = sel;
    if (sel) md8 = md;
    q8.push_back(e);
    @(negedge clk);
    st8 = 1'b0; ms8 = 1'b0;
    chk("busy_after_start8", bz8, 1);
  endtask

  task automatic wait8(input string name);
    int lat = 0;
    int bc = 0;
    while (dn8 !== 1'b1 && lat < 40) begin
      if (bz8) bc++;
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, 3);
    chk({name, "_busy_cycles"}, bc, 3);
  endtask

  task automatic launch1(input logic [143:0] a, input logic [143:0] b, input logic [143:0] e);
    mo1 = 2'b00; a1 = a; b1 = b; st1 = 1'b1;
    q1.push_back(e);
    @(negedge clk);
    st1 = 1'b0;
    chk("busy_after_start144", bz1, 1);
  endtask

  task automatic wait1(input string name);
    int lat = 0;
    int bc = 0;
    while (dn1 !== 1'b1 && lat < 300) begin
      if (bz1) bc++;
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, 144);
    chk({name, "_busy_cycles"}, bc, 144);
  endtask

  logic [159:0] tmp;
  logic [143:0] rnd_b, top_b;

  initial begin
    ms8 = 0; st8 = 0; md8 = '0; mo8 = '0; a8 = '0; b8 = '0;
    ms1 = 0; st1 = 0; md1 = '0; mo1 = '0; a1 = '0; b1 = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy8", bz8, 0);
    chk("rst_done8", dn8, 0);
    chk("rst_res8", r8, 0);
    chk("rst_moderr8", me8, 1);
    chk("rst_moderr144", me1, 1);
    rst = 1'b0;
    @(negedge clk);

    // start with no modulus loaded must be ignored
    st8 = 1'b1; mo8 = 2'b00; a8 = 8'h53; b8 = 8'hCA;
    repeat (3) begin
      @(negedge clk);
      chk("nomod_busy8", bz8, 0);
    end
    st8 = 1'b0;

    // modulus without the x^W term keeps mod_err set
    ms8 = 1'b1; md8 = 9'h01B;
    @(negedge clk);
    ms8 = 1'b0;
    chk("badmod_moderr8", me8, 1);
    st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    chk("badmod_busy8", bz8, 0);

    ms8 = 1'b1; md8 = 9'h11B;
    @(negedge clk);
    ms8 = 1'b0;
    chk("goodmod_moderr8", me8, 0);

    launch8(2'b00, 8'h53, 8'hCA, 8'h01, 1'b0, 9'h0); wait8("mul");
    launch8(2'b10, 8'h80, 8'h00, 8'h9A, 1'b0, 9'h0); wait8("sq1");
    launch8(2'b10, 8'h02, 8'hFF, 8'h04, 1'b0, 9'h0); wait8("sq2_b2b");
    launch8(2'b00, 8'h53, 8'hCA, 8'h01, 1'b0, 9'h0); wait8("mul2");
    launch8(2'b01, 8'h02, 8'h03, 8'h07, 1'b0, 9'h0); wait8("mac");
    launch8(2'b11, 8'h53, 8'hCA, 8'h01, 1'b0, 9'h0); wait8("mode11");

    // mod_sel while busy must not disturb the running or following operation
    launch8(2'b00, 8'h80, 8'h02, 8'h1B, 1'b0, 9'h0);
    ms8 = 1'b1; md8 = 9'h11D;
    fork begin @(negedge clk); ms8 = 1'b0; end join_none
    wait8("modsel_run");
    launch8(2'b00, 8'h80, 8'h02, 8'h1B, 1'b0, 9'h0); wait8("mod_kept");
    launch8(2'b00, 8'h80, 8'h02, 8'h1D, 1'b1, 9'h11D); wait8("mod_same_cycle");

    for (int i = 0; i < 5; i++) tmp[i*32 +: 32] = $urandom;
    md1 = {1'b1, tmp[143:0]};
    for (int i = 0; i < 5; i++) tmp[i*32 +: 32] = $urandom;
    rnd_b = tmp[143:0];
    ms1 = 1'b1;
    @(negedge clk);
    ms1 = 1'b0;
    chk("goodmod_moderr144", me1, 0);
    launch1(144'd1, rnd_b, rnd_b); wait1("identity144");
    top_b = '0;
    top_b[143] = 1'b1;
    launch1(144'd2, top_b, md1[143:0]); wait1("reduce144");

    // reset in the second RUN cycle aborts without a clock edge
    launch8(2'b00, 8'h53, 8'hCA, 8'h01, 1'b0, 9'h0);
    @(negedge clk);
    chk("pre_abort_busy8", bz8, 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy8", bz8, 0);
    chk("abort_done8", dn8, 0);
    chk("abort_res8", r8, 0);
    chk("abort_moderr8", me8, 1);
    void'(q8.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q144_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
